// File: rtl/stream_remove_pkg.sv
// Shared types and keep-mask helpers for stream_byte_remove.
package stream_remove_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    ST_HEAD,
    ST_BODY,
    ST_TAIL
  } state_t;

  // Bit i is set when byte lane i lies in the top cnt lanes of an nbytes-wide beat.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [7:0] cnt,
                                                     input logic [7:0] nbytes);
    logic [MAX_BYTES-1:0] m;
    int n;
    int c;
    m = '0;
    n = int'(nbytes);
    c = int'(cnt);
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < n) && (i >= n - c);
    end
    return m;
  endfunction

  function automatic logic [7:0] keep_popcount(input logic [MAX_BYTES-1:0] keep);
    logic [7:0] pc;
    pc = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      pc = pc + {7'd0, keep[i]};
    end
    return pc;
  endfunction

endpackage

// File: rtl/stream_remove_merge.sv
// Combinational byte merge: residual + head of the new beat, plus the residual that follows.
module stream_remove_merge
  import stream_remove_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]      res,
  input  logic [DATA_WD-1:0]      data,
  input  logic [DATA_BYTE_WD-1:0] keep,
  input  logic [BYTE_CNT_WD-1:0]  s,
  input  logic [BYTE_CNT_WD:0]    k,
  output logic [DATA_WD-1:0]      merged_data,
  output logic [DATA_BYTE_WD-1:0] merged_keep,
  output logic [DATA_WD-1:0]      next_res,
  output logic                    overflow
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;
  localparam logic [BYTE_CNT_WD:0] BYTES = CNT_WD'(DATA_BYTE_WD);

  logic [DATA_WD-1:0]      data_m;
  logic [DATA_WD-1:0]      merged_raw;
  logic [BYTE_CNT_WD:0]    s_ext;
  logic [BYTE_CNT_WD:0]    res_cnt;
  logic [DATA_BYTE_WD-1:0] mkeep;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_lane
      assign data_m[gi*8 +: 8]      = keep[gi]  ? data[gi*8 +: 8]       : 8'h00;
      assign merged_data[gi*8 +: 8] = mkeep[gi] ? merged_raw[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign s_ext    = {1'b0, s};
  assign res_cnt  = BYTES - s_ext;
  assign overflow = k > s_ext;

  // With s=0 the shift equals the full width and contributes nothing, as intended.
  assign merged_raw = res | (data_m >> {res_cnt, 3'b000});
  assign next_res   = data_m << {s, 3'b000};
  assign mkeep      = overflow ? '1
                    : DATA_BYTE_WD'(keep_mask(8'(res_cnt + k), 8'(DATA_BYTE_WD)));
  assign merged_keep = mkeep;

endmodule

// File: rtl/stream_byte_remove.sv
// Strips a per-packet count of leading bytes and repacks the stream into full beats.
// Define STREAM_REMOVE_SVA_EN to compile in protocol assertions.
module stream_byte_remove
  import stream_remove_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;

  state_t                  state_reg, state_next;
  logic [BYTE_CNT_WD-1:0]  s_reg, s_next;
  logic [DATA_WD-1:0]      res_reg, res_next;
  logic [DATA_BYTE_WD-1:0] tail_keep_reg, tail_keep_next;
  logic                    valid_out_reg, valid_out_next;
  logic [DATA_WD-1:0]      data_out_reg, data_out_next;
  logic [DATA_BYTE_WD-1:0] keep_out_reg, keep_out_next;
  logic                    last_out_reg, last_out_next;

  logic                    out_free;
  logic                    in_fire;
  logic [BYTE_CNT_WD-1:0]  s_sel;
  logic [BYTE_CNT_WD:0]    k;
  logic [BYTE_CNT_WD:0]    tail_cnt;
  logic [DATA_BYTE_WD-1:0] tail_mask;
  logic [DATA_WD-1:0]      merged_data;
  logic [DATA_BYTE_WD-1:0] merged_keep;
  logic [DATA_WD-1:0]      next_res;
  logic                    overflow;

  assign out_free = !valid_out_reg || ready_out;
  assign ready_in = !rst && (state_reg == ST_HEAD ? (valid_remove && out_free)
                           : state_reg == ST_BODY ? out_free : 1'b0);
  assign ready_remove = !rst && (state_reg == ST_HEAD) && valid_remove && out_free;
  assign in_fire = valid_in && ready_in;

  // The strip count is taken live on the head beat and from the latch afterwards.
  assign s_sel     = (state_reg == ST_HEAD) ? byte_remove_cnt : s_reg;
  assign k         = CNT_WD'(keep_popcount(MAX_BYTES'(keep_in)));
  assign tail_cnt  = k - {1'b0, s_sel};
  assign tail_mask = DATA_BYTE_WD'(keep_mask(8'(tail_cnt), 8'(DATA_BYTE_WD)));

  stream_remove_merge #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .BYTE_CNT_WD (BYTE_CNT_WD)
  ) u_merge (
    .res        (res_reg),
    .data       (data_in),
    .keep       (keep_in),
    .s          (s_sel),
    .k          (k),
    .merged_data(merged_data),
    .merged_keep(merged_keep),
    .next_res   (next_res),
    .overflow   (overflow)
  );

  always_comb begin
    state_next     = state_reg;
    s_next         = s_reg;
    res_next       = res_reg;
    tail_keep_next = tail_keep_reg;
    valid_out_next = valid_out_reg && !ready_out;
    data_out_next  = data_out_reg;
    keep_out_next  = keep_out_reg;
    last_out_next  = last_out_reg;
    case (state_reg)
      ST_HEAD: begin
        if (in_fire) begin
          s_next   = byte_remove_cnt;
          res_next = next_res;
          if (last_in) begin
            // A fully stripped single-beat packet still closes with an empty last beat.
            valid_out_next = 1'b1;
            data_out_next  = next_res;
            keep_out_next  = overflow ? tail_mask : '0;
            last_out_next  = 1'b1;
          end else begin
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (in_fire) begin
          valid_out_next = 1'b1;
          data_out_next  = merged_data;
          keep_out_next  = merged_keep;
          last_out_next  = last_in && !overflow;
          res_next       = next_res;
          if (last_in) begin
            if (overflow) begin
              tail_keep_next = tail_mask;
              state_next     = ST_TAIL;
            end else begin
              state_next = ST_HEAD;
            end
          end
        end
      end
      ST_TAIL: begin
        if (out_free) begin
          valid_out_next = 1'b1;
          data_out_next  = res_reg;
          keep_out_next  = tail_keep_reg;
          last_out_next  = 1'b1;
          state_next     = ST_HEAD;
        end
      end
      default: state_next = ST_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HEAD;
      s_reg         <= '0;
      res_reg       <= '0;
      tail_keep_reg <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      keep_out_reg  <= '0;
      last_out_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      s_reg         <= s_next;
      res_reg       <= res_next;
      tail_keep_reg <= tail_keep_next;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      keep_out_reg  <= keep_out_next;
      last_out_reg  <= last_out_next;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign keep_out  = keep_out_reg;
  assign last_out  = last_out_reg;

`ifdef STREAM_REMOVE_SVA_EN
  logic [DATA_BYTE_WD-1:0] keep_in_canon;
  assign keep_in_canon = DATA_BYTE_WD'(keep_mask(8'(k), 8'(DATA_BYTE_WD)));

  a_keep_contig: assert property (@(posedge clk) disable iff (rst)
    valid_in |-> keep_in == keep_in_canon);
  a_keep_full: assert property (@(posedge clk) disable iff (rst)
    valid_in && !last_in |-> &keep_in);
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    valid_out && !ready_out |=> valid_out && $stable(data_out) && $stable(keep_out)
                                && $stable(last_out));
  a_empty_only_last: assert property (@(posedge clk) disable iff (rst)
    valid_out && ready_out && keep_out == '0 |-> last_out);
`else
  // Checkers are compiled out; datapath behaviour is unchanged.
`endif

endmodule

// File: tb/tb_stream_byte_remove.sv
// Directed and randomized checks of stream_byte_remove against a byte-queue reference model.
module tb_stream_byte_remove;

  localparam int DW = 32;
  localparam int B  = 4;
  localparam int CW = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [DW-1:0] d;
    logic [B-1:0]  k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [B-1:0]  keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [B-1:0]  keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_remove;
  logic [CW-1:0] byte_remove_cnt;
  logic          ready_remove;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    pair_bad = 0;
  bit    bp_en = 1'b0;
  bit    head_pending = 1'b0;

  always #5 clk = ~clk;

  stream_byte_remove #(.DATA_WD(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_remove   (valid_remove),
    .byte_remove_cnt(byte_remove_cnt),
    .ready_remove   (ready_remove)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; fires are logged just after, while stable.
  task automatic cyc_begin();
    @(negedge clk);
    ready_out = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic cyc_end(output bit in_fired);
    beat_t b;
    #1;
    if (valid_out && ready_out) begin
      b.d = data_out;
      b.k = keep_out;
      b.l = last_out;
      got_q.push_back(b);
    end
    if (valid_remove && ready_remove && !(valid_in && ready_in)) pair_bad++;
    if (head_pending && valid_in && ready_in && !(valid_remove && ready_remove)) pair_bad++;
    in_fired = valid_in && ready_in;
  endtask

  function automatic bq_t mkseq(input int start, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(start + i));
    return q;
  endfunction

  function automatic bq_t mkrand(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference: drop the first s bytes, pack the rest MSB-first into B-byte beats.
  task automatic model(input bq_t pkt, input int s);
    bq_t ob;
    beat_t b;
    for (int i = s; i < pkt.size(); i++) ob.push_back(pkt[i]);
    if (ob.size() == 0) begin
      b.d = '0;
      b.k = '0;
      b.l = 1'b1;
      exp_q.push_back(b);
    end
    for (int i = 0; i < ob.size(); i += B) begin
      b.d = '0;
      b.k = '0;
      for (int j = 0; j < B; j++) begin
        if (i + j < ob.size()) begin
          b.d[(B-1-j)*8 +: 8] = ob[i+j];
          b.k[B-1-j] = 1'b1;
        end
      end
      b.l = (i + B >= ob.size());
      exp_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input bq_t pkt, input int s, input int nsend, input bit chk_tail);
    int nb;
    nb = (pkt.size() + B - 1) / B;
    for (int bi = 0; bi < nsend; bi++) begin
      logic [DW-1:0] d;
      logic [B-1:0]  kp;
      bit            fired;
      int            guard;
      d = $urandom;
      kp = '0;
      for (int j = 0; j < B; j++) begin
        if (bi * B + j < pkt.size()) begin
          d[(B-1-j)*8 +: 8] = pkt[bi*B+j];
          kp[B-1-j] = 1'b1;
        end
      end
      fired = 1'b0;
      guard = 0;
      while (!fired && guard < 200) begin
        cyc_begin();
        valid_in        = 1'b1;
        data_in         = d;
        keep_in         = kp;
        last_in         = (bi == nb - 1);
        valid_remove    = (bi == 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
        byte_remove_cnt = (bi == 0) ? CW'(s) : CW'($urandom_range(0, B - 1));
        head_pending    = (bi == 0);
        cyc_end(fired);
        guard++;
      end
      chk("in_fire", 64'(fired), 64'd1);
    end
    if (chk_tail) begin
      bit f;
      cyc_begin();
      ready_out    = 1'b1;
      valid_in     = 1'b0;
      valid_remove = 1'b1;
      head_pending = 1'b0;
      cyc_end(f);
      chk("tail_ready_in", 64'(ready_in), 64'd0);
      chk("tail_ready_remove", 64'(ready_remove), 64'd0);
    end
  endtask

  task automatic run_pkt(input bq_t pkt, input int s, input bit chk_tail);
    model(pkt, s);
    send_pkt(pkt, s, (pkt.size() + B - 1) / B, chk_tail);
  endtask

  task automatic drain();
    bit f;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      cyc_begin();
      valid_in     = 1'b0;
      valid_remove = 1'b0;
      head_pending = 1'b0;
      cyc_end(f);
      n++;
    end
    repeat (3) begin
      cyc_begin();
      valid_in     = 1'b0;
      valid_remove = 1'b0;
      cyc_end(f);
    end
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 64'(got_q[i].d), 64'(exp_q[i].d));
      chk({tag, "_keep"}, 64'(got_q[i].k), 64'(exp_q[i].k));
      chk({tag, "_last"}, 64'(got_q[i].l), 64'(exp_q[i].l));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit f;
    rst             = 1'b1;
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    ready_out       = 1'b1;
    valid_remove    = 1'b0;
    byte_remove_cnt = '0;

    // Reset: readies stay low even with both valids up, outputs clear.
    cyc_begin();
    rst = 1'b1;
    valid_in = 1'b1;
    valid_remove = 1'b1;
    cyc_end(f);
    cyc_begin();
    cyc_end(f);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_ready_remove", 64'(ready_remove), 64'd0);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_keep_out", 64'(keep_out), 64'd0);
    chk("rst_last_out", 64'(last_out), 64'd0);
    cyc_begin();
    rst = 1'b0;
    valid_in = 1'b0;
    valid_remove = 1'b0;
    cyc_end(f);
    got_q.delete();

    run_pkt(mkseq(8'h00, 14), 0, 1'b0);
    drain();
    compare("pass_s0");

    run_pkt(mkseq(8'h00, 12), 1, 1'b0);
    drain();
    compare("s1_full");

    run_pkt(mkseq(8'h00, 5), 3, 1'b0);
    run_pkt(mkseq(8'h10, 9), 3, 1'b0);
    drain();
    compare("s3_short");

    run_pkt(mkseq(8'h00, 7), 1, 1'b1);
    drain();
    compare("tail");

    run_pkt(mkseq(8'h00, 1), 2, 1'b0);
    run_pkt(mkseq(8'h20, 3), 1, 1'b0);
    run_pkt(mkseq(8'h30, 4), 0, 1'b0);
    drain();
    compare("head_last");

    bp_en = 1'b1;
    for (int p = 0; p < 25; p++) begin
      run_pkt(mkrand($urandom_range(1, 20)), $urandom_range(0, B - 1), 1'b0);
    end
    drain();
    compare("random");
    bp_en = 1'b0;

    // Abandon a packet mid-flight with reset, then a clean packet must follow.
    send_pkt(mkseq(8'h40, 16), 1, 2, 1'b0);
    cyc_begin();
    rst = 1'b1;
    valid_in = 1'b0;
    valid_remove = 1'b0;
    head_pending = 1'b0;
    cyc_end(f);
    cyc_begin();
    cyc_end(f);
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    cyc_begin();
    rst = 1'b0;
    cyc_end(f);
    got_q.delete();
    exp_q.delete();
    run_pkt(mkseq(8'h80, 10), 2, 1'b0);
    drain();
    compare("post_rst");

    chk("remove_pairing", 64'(pair_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
